fx2_dac_stream: RTL and testbench

- Parametrised successor to the FX2LP slave-FIFO-to-DAC path.
- Pulls bytes from the FX2LP slave FIFO into a local sample FIFO and assembles 8- or 16-bit DAC samples.
- Issues samples to the DAC at a programmable divider rate, with prefill priming, selectable underrun behaviour and a saturating underrun counter.
- Sits between the FX2 FD bus and the ADDA DAC pins. Control inputs come from Qsys PIO registers.

---
 rtl/fx2_dac_stream.sv | 183 ++++++++++++++++++
 tb/tb_fx2_dac_stream.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_dac_stream.sv
// fx2_dac_stream
// Streams bytes from the FX2LP slave FIFO into a local sample FIFO. Each
// byte becomes one DAC sample (DAC_W=8), or each pair of bytes, low byte
// first, becomes one sample (DAC_W=16). Samples are sent to the DAC at a
// programmable divider rate. Nothing is sent until the FIFO has been primed
// to half full. When the FIFO runs empty the DAC either holds its last
// sample or returns to midscale, and a saturating underrun counter advances.
//
// Parameters
//   DIV_W  width of the rate divider input
//   DEPTH  sample FIFO depth (power of 2, >= 4)
//   DAC_W  DAC sample width (8 or 16)
//
// Ports
//   CLK, RESET_N     IFCLK clock, asynchronous active-low reset
//   ENABLE           stream enable; a low level flushes the stream
//   DIV              clocks per sample (0 and 1 both mean every clock)
//   UNDERRUN_MODE    0 = hold last sample on underrun, 1 = go to midscale
//   CLR_UNDERRUN     synchronous clear of UNDERRUN_CNT
//   FD_IN            FX2 FIFO data bus
//   FLAGN_EMPTY_N    FX2 empty flag, active low (1 = data available)
//   SLOEN, SLRDN     FX2 output enable and read strobe, both active low
//   DAC_DATA         DAC sample
//   DAC_STROBE       one-cycle pulse for each sample taken from the FIFO
//   UNDERRUN_CNT     saturating underrun count
//   FILL             FIFO occupancy in complete samples
module fx2_dac_stream #(
    parameter int DIV_W = 26,
    parameter int DEPTH = 16,
    parameter int DAC_W = 8
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       ENABLE,
    input  logic [DIV_W-1:0]           DIV,
    input  logic                       UNDERRUN_MODE,
    input  logic                       CLR_UNDERRUN,
    input  logic [7:0]                 FD_IN,
    input  logic                       FLAGN_EMPTY_N,
    output logic                       SLOEN,
    output logic                       SLRDN,
    output logic [DAC_W-1:0]           DAC_DATA,
    output logic                       DAC_STROBE,
    output logic [15:0]                UNDERRUN_CNT,
    output logic [$clog2(DEPTH):0]     FILL
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [DAC_W-1:0] MIDSCALE  = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [AW:0]      FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]      PRIME_LVL = (AW+1)'(DEPTH / 2);

    logic [DAC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill;
    logic [AW:0]      fill_next;
    logic             primed;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_m1;

    logic             rd;
    logic             push;
    logic [DAC_W-1:0] push_data;
    logic             tick;
    logic             pop;
    logic             underrun;

    assign rd    = ENABLE & ~SLOEN & FLAGN_EMPTY_N & (fill < FULL_LVL);
    assign SLRDN = ~rd;
    assign FILL  = fill;

    // Byte assembly. In 16-bit mode the first byte is parked as the low half
    // and only the second byte produces a push, so a half sample never shows
    // up in FILL.
    generate
        if (DAC_W == 16) begin : g_asm16
            logic [7:0] lo_byte;
            logic       have_lo;

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    lo_byte <= '0;
                    have_lo <= 1'b0;
                end else if (!ENABLE) begin
                    lo_byte <= '0;
                    have_lo <= 1'b0;
                end else if (rd) begin
                    if (!have_lo) begin
                        lo_byte <= FD_IN;
                        have_lo <= 1'b1;
                    end else begin
                        have_lo <= 1'b0;
                    end
                end
            end

            assign push      = rd & have_lo;
            assign push_data = {FD_IN, lo_byte};
        end else begin : g_asm8
            assign push      = rd;
            assign push_data = FD_IN;
        end
    endgenerate

    // Terminal count of the divider; DIV of 0 or 1 collapses to a tick every
    // clock. Comparing with >= lets a shrinking DIV take effect at once.
    assign div_m1   = (DIV <= DIV_W'(1)) ? '0 : DIV - 1'b1;
    assign tick     = ENABLE & (cnt == '0);
    assign pop      = tick & primed & (fill != '0);
    assign underrun = tick & primed & (fill == '0);

    always_comb begin
        fill_next = fill;
        if (push && !pop) begin
            fill_next = fill + 1'b1;
        end else if (pop && !push) begin
            fill_next = fill - 1'b1;
        end
    end

    // Storage carries no reset; only slots behind wr_ptr are ever read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (!ENABLE || cnt >= div_m1) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            SLOEN        <= 1'b1;
            DAC_DATA     <= MIDSCALE;
            DAC_STROBE   <= 1'b0;
            UNDERRUN_CNT <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            primed       <= 1'b0;
        end else begin
            SLOEN      <= ~ENABLE;
            DAC_STROBE <= 1'b0;

            // Clear wins over a coincident underrun.
            if (CLR_UNDERRUN) begin
                UNDERRUN_CNT <= '0;
            end else if (underrun && UNDERRUN_CNT != 16'hFFFF) begin
                UNDERRUN_CNT <= UNDERRUN_CNT + 1'b1;
            end

            if (!ENABLE) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fill     <= '0;
                primed   <= 1'b0;
                DAC_DATA <= MIDSCALE;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    DAC_DATA   <= mem[rd_ptr];
                    DAC_STROBE <= 1'b1;
                    rd_ptr     <= rd_ptr + 1'b1;
                end else if (underrun && UNDERRUN_MODE) begin
                    DAC_DATA <= MIDSCALE;
                end
                fill   <= fill_next;
                primed <= primed | (fill_next >= PRIME_LVL);
            end
        end
    end

endmodule

// File: tb/tb_fx2_dac_stream.sv
module tb_fx2_dac_stream;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [25:0] div = '0;
    logic        mode = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  fd_a = '0;
    logic        flag_a;
    logic        flag_allow = 1'b1;
    logic        q_nonempty = 1'b0;
    logic        SLOEN_A, SLRDN_A, DAC_STROBE_A;
    logic [7:0]  DAC_DATA_A;
    logic [15:0] UCNT_A;
    logic [4:0]  FILL_A;

    logic        rst16_n = 1'b0;
    logic        en16 = 1'b0;
    logic [25:0] div16 = '0;
    logic        mode16 = 1'b0;
    logic        clr16 = 1'b0;
    logic [7:0]  fd16 = '0;
    logic        flag16 = 1'b0;
    logic        SLOEN16, SLRDN16, DAC_STROBE16;
    logic [15:0] DAC_DATA16;
    logic [15:0] UCNT16;
    logic [4:0]  FILL16;

    int n_total = 0;
    int n_pass = 0;
    bit seen_full = 0;
    int fill_peak = 0;
    logic [7:0] q[$];

    always #5 CLK = ~CLK;

    assign flag_a = flag_allow & q_nonempty;

    fx2_dac_stream #(.DIV_W(26), .DEPTH(16), .DAC_W(8)) dut (
        .CLK(CLK), .RESET_N(rst_n), .ENABLE(en), .DIV(div),
        .UNDERRUN_MODE(mode), .CLR_UNDERRUN(clr), .FD_IN(fd_a),
        .FLAGN_EMPTY_N(flag_a), .SLOEN(SLOEN_A), .SLRDN(SLRDN_A),
        .DAC_DATA(DAC_DATA_A), .DAC_STROBE(DAC_STROBE_A),
        .UNDERRUN_CNT(UCNT_A), .FILL(FILL_A)
    );

    fx2_dac_stream #(.DIV_W(26), .DEPTH(16), .DAC_W(16)) dut16 (
        .CLK(CLK), .RESET_N(rst16_n), .ENABLE(en16), .DIV(div16),
        .UNDERRUN_MODE(mode16), .CLR_UNDERRUN(clr16), .FD_IN(fd16),
        .FLAGN_EMPTY_N(flag16), .SLOEN(SLOEN16), .SLRDN(SLRDN16),
        .DAC_DATA(DAC_DATA16), .DAC_STROBE(DAC_STROBE16),
        .UNDERRUN_CNT(UCNT16), .FILL(FILL16)
    );

    // FX2 slave FIFO model: a byte is consumed on each edge with SLRDN low,
    // the next byte is presented on the following falling edge.
    always @(posedge CLK) begin
        if (!SLRDN_A && q.size() > 0) void'(q.pop_front());
    end

    always @(negedge CLK) begin
        q_nonempty = (q.size() > 0);
        fd_a = (q.size() > 0) ? q[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_strobe(input int limit, output int waited, output int maxfill);
        waited = 0;
        maxfill = 0;
        do begin
            @(negedge CLK);
            waited++;
            if (!DAC_STROBE_A && int'(FILL_A) > maxfill) maxfill = int'(FILL_A);
            if (int'(FILL_A) > fill_peak) fill_peak = int'(FILL_A);
            if (FILL_A == 5'd16 && SLRDN_A) seen_full = 1;
        end while (!DAC_STROBE_A && waited < limit);
        chk("strobe_seen", DAC_STROBE_A, 1);
    endtask

    task automatic feed16(input logic [7:0] b);
        int n;
        fd16 = b;
        flag16 = 1'b1;
        #1;
        n = 0;
        while (SLRDN16 !== 1'b0 && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n == 20) chk("slrdn16_low", SLRDN16, 0);
        @(posedge CLK);
        @(negedge CLK);
        flag16 = 1'b0;
    endtask

    initial begin
        int w, mf;
        logic [7:0] exp8;

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_sloen", SLOEN_A, 1);
        chk("rst_slrdn", SLRDN_A, 1);
        chk("rst_dac", DAC_DATA_A, 8'h80);
        chk("rst_strobe", DAC_STROBE_A, 0);
        chk("rst_ucnt", UCNT_A, 0);
        chk("rst_fill", FILL_A, 0);
        chk("rst_dac16", DAC_DATA16, 16'h8000);
        rst_n = 1'b1;
        rst16_n = 1'b1;
        @(negedge CLK);

        // 16-bit: reset after one byte discards the half sample
        en16 = 1'b1;
        @(negedge CLK);
        feed16(8'hEE);
        rst16_n = 1'b0;
        #1;
        chk("rst16_fill", FILL16, 0);
        chk("rst16_dac", DAC_DATA16, 16'h8000);
        chk("rst16_sloen", SLOEN16, 1);
        @(negedge CLK);
        rst16_n = 1'b1;
        feed16(8'h34);
        feed16(8'h12);
        feed16(8'h78);
        feed16(8'h56);
        for (int i = 1; i <= 12; i++) feed16(8'(i));
        chk("fill16_primed", FILL16, 8);
        @(negedge CLK);
        chk("strobe16_a", DAC_STROBE16, 1);
        chk("dac16_a", DAC_DATA16, 16'h1234);
        @(negedge CLK);
        chk("dac16_b", DAC_DATA16, 16'h5678);
        en16 = 1'b0;

        // 8-bit stream at DIV=4 with priming
        div = 26'd4;
        for (int i = 1; i <= 32; i++) q.push_back(8'(i));
        en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            wait_strobe(40, w, mf);
            if (k == 1) chk("prime_fill", (mf >= 8), 1);
            else chk("gap_div4", w, 4);
            chk("stream_dac", DAC_DATA_A, k);
        end
        chk("stream_ucnt", UCNT_A, 0);
        chk("full_seen", seen_full, 1);
        chk("fill_peak", fill_peak, 16);
        en = 1'b0;
        @(negedge CLK);
        chk("flush1_fill", FILL_A, 0);
        chk("flush1_dac", DAC_DATA_A, 8'h80);

        // underrun, hold mode then midscale mode
        div = 26'd2;
        for (int i = 0; i < 7; i++) q.push_back(8'h11 + 8'(i));
        q.push_back(8'hA5);
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_strobe(40, w, mf);
            exp8 = (k < 7) ? 8'h11 + 8'(k) : 8'hA5;
            chk("drain_dac", DAC_DATA_A, exp8);
        end
        chk("drain_fill", FILL_A, 0);
        @(negedge CLK);
        chk("ur_before", UCNT_A, 0);
        @(negedge CLK);
        chk("ur1_cnt", UCNT_A, 1);
        chk("ur1_dac", DAC_DATA_A, 8'hA5);
        chk("ur1_strobe", DAC_STROBE_A, 0);
        @(negedge CLK);
        chk("ur_between", UCNT_A, 1);
        @(negedge CLK);
        chk("ur2_cnt", UCNT_A, 2);
        chk("ur2_dac", DAC_DATA_A, 8'hA5);
        mode = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("ur3_cnt", UCNT_A, 3);
        chk("ur3_dac_mid", DAC_DATA_A, 8'h80);

        // DIV=0 then DIV=1: a tick every clock (counter wraps first)
        div = 26'd0;
        @(negedge CLK);
        chk("div0_wrap", UCNT_A, 3);
        @(negedge CLK);
        chk("div0_a", UCNT_A, 4);
        @(negedge CLK);
        chk("div0_b", UCNT_A, 5);
        div = 26'd1;
        @(negedge CLK);
        chk("div1_a", UCNT_A, 6);
        @(negedge CLK);
        chk("div1_b", UCNT_A, 7);

        // clear against underrun, then saturation
        clr = 1'b1;
        @(negedge CLK);
        chk("clr_vs_ur", UCNT_A, 0);
        clr = 1'b0;
        repeat (65534) @(posedge CLK);
        @(negedge CLK);
        chk("cnt_fffe", UCNT_A, 16'hFFFE);
        @(negedge CLK);
        chk("sat_1", UCNT_A, 16'hFFFF);
        @(negedge CLK);
        chk("sat_2", UCNT_A, 16'hFFFF);
        @(negedge CLK);
        chk("sat_3", UCNT_A, 16'hFFFF);
        clr = 1'b1;
        @(negedge CLK);
        chk("clr_sat", UCNT_A, 0);
        clr = 1'b0;
        repeat (5) @(negedge CLK);
        chk("cnt_5", UCNT_A, 5);
        en = 1'b0;
        @(negedge CLK);
        chk("retain_cnt", UCNT_A, 5);

        // disable with FILL=10
        div = 26'd1000;
        for (int i = 0; i < 10; i++) q.push_back(8'h60 + 8'(i));
        en = 1'b1;
        repeat (20) @(negedge CLK);
        chk("fill10", FILL_A, 10);
        chk("fill10_nostrobe", DAC_STROBE_A, 0);
        en = 1'b0;
        #1;
        chk("drop_slrdn", SLRDN_A, 1);
        chk("drop_sloen_old", SLOEN_A, 0);
        @(negedge CLK);
        chk("drop_fill", FILL_A, 0);
        chk("drop_dac", DAC_DATA_A, 8'h80);
        chk("drop_sloen", SLOEN_A, 1);
        chk("drop_ucnt", UCNT_A, 5);

        // re-enable: priming repeats
        div = 26'd4;
        for (int i = 0; i < 128; i++) q.push_back(8'h40 + 8'(i));
        en = 1'b1;
        wait_strobe(40, w, mf);
        chk("reprime_fill", (mf >= 8), 1);
        chk("reprime_dac", DAC_DATA_A, 8'h40);
        wait_strobe(40, w, mf);
        chk("reprime_gap", w, 4);
        chk("reprime_dac2", DAC_DATA_A, 8'h41);
        en = 1'b0;
        @(negedge CLK);

        // simultaneous push and pop at FILL=5
        div = 26'd0;
        en = 1'b1;
        repeat (25) @(negedge CLK);
        chk("steady_fill8", FILL_A, 8);
        flag_allow = 1'b0;
        repeat (3) @(negedge CLK);
        chk("fill5", FILL_A, 5);
        flag_allow = 1'b1;
        @(negedge CLK);
        chk("pushpop_fill", FILL_A, 5);
        chk("pushpop_strobe", DAC_STROBE_A, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
